mp_out_streamer: RTL and testbench
==================================

Name: mp_out_streamer

Overview:
- Output stage directly downstream of the motion pipeline. Consumes the highlighted_pixel / pixel_valid / pixel_last stream.
- Buffers pixels in a small FIFO, tracks raster position against the programmed width/height, and emits a ready/valid output stream. Each beat carries start-of-frame (m_tuser) and end-of-line (m_tlast) markers for the video sink.
- The motion pipeline has no backpressure input, so buffer overflow and frame-geometry mismatches are reported through sticky status flags rather than by stalling.

Parameters:
- DATA_W, 32, pixel width in bits.
- WIDTH_BITS, 11, width of the frame-width field.
- HEIGHT_BITS, 10, width of the frame-height field.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  accept input when high.
- width  in  WIDTH_BITS  pixels per line.
- height  in  HEIGHT_BITS  lines per frame.
- highlighted_pixel  in  DATA_W  pixel from the motion pipeline.
- pixel_valid  in  1  highlighted_pixel is valid this cycle.
- pixel_last  in  1  marks the last pixel of the frame from the motion pipeline.
- m_tdata  out  DATA_W  output pixel.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  sink ready.
- m_tuser  out  1  beat is the first pixel of a frame.
- m_tlast  out  1  beat is the last pixel of a line.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is handshaken.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- frame_err  out  1  sticky flag: a geometry mismatch occurred.
- clear_status  in  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset (rst=0, async): all outputs 0; FIFO empty; col/row counters 0; latched width/height 0.
- Accept condition: enable & pixel_valid. With enable=0, input is ignored and counters hold (no reset of position).
- Geometry latching: width/height are latched when a pixel is accepted at col=0,row=0. Changes mid-frame take effect at the next frame.
- Per accepted pixel, computed from the latched values:
  - sof = (col==0 & row==0)
  - eol = (col==W-1)
  - eof = eol & (row==H-1)
- Counter advance: col increments; at eol, col←0 and row increments; at eof, row←0.
- pixel_last=1 with eof=0: frame_err←1; the entry is stored with eol=1 and eof=1; counters resync to 0,0.
- eof=1 with pixel_last=0: frame_err←1; counters wrap normally.
- Latched W or H of 0: pixel is dropped (not stored), frame_err←1, counters stay 0,0.
- FIFO entry contents: {data, sof, eol, eof}.
  - Push when accepted and (not full, or full with a pop in the same cycle).
  - Full and no pop: pixel dropped, overflow←1. Counters still advance so geometry stays aligned.
- Output side (first-word fall-through, registered storage):
  - m_tvalid = !empty; m_tdata/m_tuser/m_tlast come from the head entry.
  - Pop on m_tvalid & m_tready.
  - While m_tvalid=1 and m_tready=0, all m_* outputs stay stable.
  - Latency: a pixel accepted in cycle N into an empty FIFO gives m_tvalid=1 in cycle N+1.
- frame_done: registered; pulses in the cycle after the pop of an entry with eof=1.
- fifo_level: updated each cycle; simultaneous push and pop leaves it unchanged.
- Empty FIFO with m_tready=1: no pop; m_tvalid stays 0.
- clear_status: clears overflow and frame_err. If a new error event occurs in the same cycle, set wins.
- Output ordering: strictly input order; no reordering or duplication.

Test Plan:
- Basic frame: width=4, height=2, 8 pixels 0x0..0x7 with pixel_last on the 8th, m_tready=1.
  - m_tvalid rises 1 cycle after the first accept; beats 0..7 in order.
  - m_tuser on beat 0 only; m_tlast on beats 3 and 7.
  - frame_done pulses once, 1 cycle after beat 7; overflow=0, frame_err=0.
- Overflow: FIFO_DEPTH=16, m_tready=0, 20 pixels pushed.
  - fifo_level=16; overflow=1.
  - Raising m_tready drains exactly pixels 0..15 in order.
  - The next frame's m_tuser lands correctly, because counters advanced through the dropped pixels.
- Early last: width=4, height=2, pixel_last on the 5th pixel.
  - frame_err=1; beat 4 has m_tlast=1 and produces frame_done.
  - The 6th pixel carries m_tuser=1.
  - clear_status returns frame_err to 0.
- Full with simultaneous push/pop: FIFO full, m_tready=1 and a pixel accepted in the same cycle.
  - No overflow; fifo_level stays 16.
  - Held backpressure (m_tready toggled 0/1) keeps m_tdata stable while stalled.
- Mid-frame width change and reset:
  - Change width 4→8 after pixel 2; the current frame still uses 4, the next frame uses 8.
  - Assert rst mid-frame: all outputs 0 immediately; the first pixel after release gets m_tuser=1.

Source files
------------

// File: rtl/mp_out_streamer.sv
// Purpose : output stage after the motion pipeline; FIFO-buffers pixels, tags SOF/EOL, streams ready/valid.
// Latency : a pixel accepted into an empty FIFO is presented on m_* one cycle later (FWFT, registered storage).
// Backpressure: none upstream; a full FIFO drops pixels and sets sticky overflow, geometry errors set frame_err.
//
// Ports: clk/rst (async active-low); enable gates input acceptance; width/height give frame geometry,
// latched at the first pixel of each frame; highlighted_pixel/pixel_valid/pixel_last is the input stream;
// m_tdata/m_tvalid/m_tready/m_tuser(SOF)/m_tlast(EOL) is the output stream; frame_done pulses after the
// last beat of a frame leaves; fifo_level is occupancy; overflow/frame_err are sticky, cleared by clear_status.
module mp_out_streamer #(
    parameter int DATA_W      = 32,
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [WIDTH_BITS-1:0]         width,
    input  logic [HEIGHT_BITS-1:0]        height,
    input  logic [DATA_W-1:0]             highlighted_pixel,
    input  logic                          pixel_valid,
    input  logic                          pixel_last,
    output logic [DATA_W-1:0]             m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tuser,
    output logic                          m_tlast,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clear_status
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } entry_t;

    entry_t                 mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic [WIDTH_BITS-1:0]  col, w_lat;
    logic [HEIGHT_BITS-1:0] row, h_lat;

    // ---------------- input side: raster tracking ----------------
    logic                   accept, at_origin, geom_bad, take;
    logic [WIDTH_BITS-1:0]  eff_w, w_last;
    logic [HEIGHT_BITS-1:0] eff_h, h_last;
    logic                   eol_geom, eof_geom, err_set;
    logic                   empty, full, push, pop, drop;
    entry_t                 in_entry, head;

    assign accept    = enable & pixel_valid;
    assign at_origin = (col == '0) && (row == '0);

    // The first pixel of a frame uses the live geometry (it is being latched on this
    // same pixel); every later pixel of the frame uses the latched copy.
    assign eff_w  = at_origin ? width  : w_lat;
    assign eff_h  = at_origin ? height : h_lat;
    assign w_last = eff_w - WIDTH_BITS'(1);
    assign h_last = eff_h - HEIGHT_BITS'(1);

    assign geom_bad = (eff_w == '0) || (eff_h == '0);
    assign eol_geom = (col == w_last);
    assign eof_geom = eol_geom && (row == h_last);

    // Zero geometry cannot be rastered, so such pixels never reach the FIFO.
    assign take = accept & ~geom_bad;

    // An upstream frame end always closes both the line and the frame, whether or not
    // it agrees with the programmed geometry, so the sink resyncs on it.
    assign in_entry.data = highlighted_pixel;
    assign in_entry.sof  = at_origin;
    assign in_entry.eol  = eol_geom | pixel_last;
    assign in_entry.eof  = eof_geom | pixel_last;

    assign err_set = accept & (geom_bad | (pixel_last ^ eof_geom));

    // ---------------- FIFO control ----------------
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = ~empty & m_tready;
    assign push  = take & (~full | pop);
    assign drop  = take & full & ~pop;

    assign head = mem[rd_ptr];

    // Outputs are forced to zero while empty so reset and idle present a clean bus.
    assign m_tvalid   = ~empty;
    assign m_tdata    = empty ? '0 : head.data;
    assign m_tuser    = ~empty & head.sof;
    assign m_tlast    = ~empty & head.eol;
    assign fifo_level = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            col        <= '0;
            row        <= '0;
            w_lat      <= '0;
            h_lat      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (accept && at_origin) begin
                w_lat <= width;
                h_lat <= height;
            end

            // Counters follow every valid pixel, even dropped ones, so the raster
            // position stays aligned with the upstream stream after an overflow.
            if (take) begin
                if (pixel_last || eof_geom) begin
                    col <= '0;
                    row <= '0;
                end else if (eol_geom) begin
                    col <= '0;
                    row <= row + HEIGHT_BITS'(1);
                end else begin
                    col <= col + WIDTH_BITS'(1);
                end
            end

            frame_done <= pop & head.eof;

            // A new event in the same cycle as a clear leaves the flag set.
            overflow  <= (overflow  & ~clear_status) | drop;
            frame_err <= (frame_err & ~clear_status) | err_set;
        end
    end

endmodule

// File: tb/tb_mp_out_streamer.sv
module tb_mp_out_streamer;

    localparam int DW = 32;
    localparam int WB = 11;
    localparam int HB = 10;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [WB-1:0] width = '0;
    logic [HB-1:0] height = '0;
    logic [DW-1:0] highlighted_pixel = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_last = 1'b0;
    logic          m_tready = 1'b0;
    logic          clear_status = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tuser, m_tlast, frame_done, overflow, frame_err;
    logic [LW-1:0] fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mp_out_streamer #(
        .DATA_W(DW), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .width(width), .height(height),
        .highlighted_pixel(highlighted_pixel), .pixel_valid(pixel_valid), .pixel_last(pixel_last),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .frame_done(frame_done), .fifo_level(fifo_level),
        .overflow(overflow), .frame_err(frame_err), .clear_status(clear_status)
    );

    typedef struct {
        logic          rst_before;
        logic [WB-1:0] w;
        logic [HB-1:0] h;
        logic          vld;
        logic          last;
        logic [DW-1:0] dat;
        logic          rdy;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic          e_user;
        logic          e_last;
        logic          e_done;
        logic [LW-1:0] e_lvl;
        logic          e_ovf;
        logic          e_ferr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rb, input int w, input int h, input logic vld,
                                input logic last, input int dat, input logic rdy,
                                input logic e_vld, input int e_dat, input logic e_user,
                                input logic e_last, input logic e_done, input int e_lvl,
                                input logic e_ovf, input logic e_ferr);
        vec_t v;
        v.rst_before = rb;
        v.w = WB'(w);   v.h = HB'(h);
        v.vld = vld;    v.last = last;   v.dat = DW'(dat);  v.rdy = rdy;
        v.e_vld = e_vld; v.e_dat = DW'(e_dat); v.e_user = e_user; v.e_last = e_last;
        v.e_done = e_done; v.e_lvl = LW'(e_lvl); v.e_ovf = e_ovf; v.e_ferr = e_ferr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pixel_valid = 1'b0;
        pixel_last = 1'b0;
        m_tready = 1'b0;
        clear_status = 1'b0;
        enable = 1'b1;
        #1;
        check("reset_outputs", 64'({m_tvalid, m_tdata, m_tuser, m_tlast, frame_done,
                                     fifo_level, overflow, frame_err}), 64'd0);
        step();
        rst = 1'b1;
    endtask

    task automatic push_px(input int d, input logic last);
        pixel_valid = 1'b1;
        highlighted_pixel = DW'(d);
        pixel_last = last;
        step();
        pixel_valid = 1'b0;
        pixel_last = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] act, exp;

        // Basic frame 4x2, sink always ready: each beat appears the cycle after its accept.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(k == 0, 4, 2, 1, k == 7, k, 1,
                              1, k, k == 0, (k == 3) || (k == 7), 0, 1, 0, 0));
        vecs.push_back(mk(0, 4, 2, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4, 2, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        // Early pixel_last on the 5th pixel: forced EOL/EOF, error, next pixel starts a frame.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(k == 0, 4, 2, 1, k == 4, 'h10 + k, 1,
                              1, 'h10 + k, (k == 0) || (k == 5), (k == 3) || (k == 4),
                              k == 5, 1, 0, k >= 4));
        vecs.push_back(mk(0, 4, 2, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1));

        #2;
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            width = vecs[i].w;
            height = vecs[i].h;
            pixel_valid = vecs[i].vld;
            pixel_last = vecs[i].last;
            highlighted_pixel = vecs[i].dat;
            m_tready = vecs[i].rdy;
            step();
            act = 64'({m_tvalid,
                       vecs[i].e_vld ? m_tdata : 32'd0,
                       vecs[i].e_vld ? m_tuser : 1'b0,
                       vecs[i].e_vld ? m_tlast : 1'b0,
                       frame_done, fifo_level, overflow, frame_err});
            exp = 64'({vecs[i].e_vld,
                       vecs[i].e_vld ? vecs[i].e_dat : 32'd0,
                       vecs[i].e_vld ? vecs[i].e_user : 1'b0,
                       vecs[i].e_vld ? vecs[i].e_last : 1'b0,
                       vecs[i].e_done, vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_ferr});
            check($sformatf("vec%0d", i), act, exp);
        end
        pixel_valid = 1'b0;
        pixel_last = 1'b0;

        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clear_frame_err", 64'(frame_err), 64'd0);

        // Overflow: 20 pixels into a 16-deep FIFO with the sink stalled.
        do_reset();
        width = 4;
        height = 5;
        for (int i = 0; i < 20; i++) push_px('h100 + i, i == 19);
        check("ovf_level_flags", 64'({m_tvalid, fifo_level, overflow, frame_err}),
              64'({1'b1, 5'd16, 1'b1, 1'b0}));
        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf_drain%0d", k), 64'({m_tvalid, m_tdata, m_tuser, m_tlast}),
                  64'({1'b1, 32'('h100 + k), k == 0, (k % 4) == 3}));
            step();
        end
        check("ovf_drained", 64'({m_tvalid, fifo_level, frame_done}), 64'd0);
        push_px('h200, 1'b0);
        check("ovf_next_sof", 64'({m_tvalid, m_tdata, m_tuser}), 64'({1'b1, 32'h200, 1'b1}));

        // Full FIFO with push and pop in the same cycle, then held backpressure.
        do_reset();
        width = 4;
        height = 8;
        for (int i = 0; i < 16; i++) push_px('h300 + i, 1'b0);
        check("full_level", 64'({fifo_level, overflow}), 64'({5'd16, 1'b0}));
        m_tready = 1'b1;
        push_px('h310, 1'b0);
        check("simul_push_pop", 64'({fifo_level, overflow, m_tdata}), 64'({5'd16, 1'b0, 32'h301}));
        m_tready = 1'b0;
        step();
        check("stall1", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'h301}));
        step();
        check("stall2", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'h301}));
        m_tready = 1'b1;
        step();
        check("stall_pop", 64'({m_tdata, fifo_level}), 64'({32'h302, 5'd15}));
        m_tready = 1'b0;
        step();
        check("stall3", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'h302}));

        // Width change mid-frame only affects the next frame.
        do_reset();
        width = 4;
        height = 2;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) width = 8;
            push_px('h400 + i, i == 7);
            check($sformatf("wchg_f1_%0d", i), 64'({m_tdata, m_tuser, m_tlast}),
                  64'({32'('h400 + i), i == 0, (i == 3) || (i == 7)}));
        end
        for (int i = 0; i < 10; i++) begin
            push_px('h500 + i, 1'b0);
            check($sformatf("wchg_f2_%0d", i), 64'({m_tdata, m_tuser, m_tlast}),
                  64'({32'('h500 + i), i == 0, i == 7}));
        end
        // Reset in the middle of frame 2, then the first pixel after release starts a frame.
        do_reset();
        width = 8;
        height = 2;
        m_tready = 1'b1;
        push_px('h600, 1'b0);
        check("post_reset_sof", 64'({m_tvalid, m_tdata, m_tuser}), 64'({1'b1, 32'h600, 1'b1}));

        // enable=0 ignores input; zero width drops pixel and flags an error.
        do_reset();
        width = 4;
        height = 2;
        enable = 1'b0;
        push_px('h7ff, 1'b0);
        check("enable_low", 64'({m_tvalid, fifo_level, frame_err}), 64'd0);
        enable = 1'b1;
        width = 0;
        push_px('h700, 1'b0);
        check("zero_width", 64'({m_tvalid, fifo_level, frame_err}), 64'({1'b0, 5'd0, 1'b1}));
        width = 4;
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("zero_width_clear", 64'(frame_err), 64'd0);
        m_tready = 1'b1;
        push_px('h701, 1'b0);
        check("zero_width_resync", 64'({m_tvalid, m_tdata, m_tuser}), 64'({1'b1, 32'h701, 1'b1}));

        // Geometry EOF without pixel_last while clearing: error still latches.
        do_reset();
        width = 1;
        height = 1;
        m_tready = 1'b1;
        clear_status = 1'b1;
        push_px('h800, 1'b0);
        clear_status = 1'b0;
        check("late_last_set_wins", 64'({m_tuser, m_tlast, frame_err}), 64'({1'b1, 1'b1, 1'b1}));
        step();
        check("late_last_done", 64'({frame_done, m_tvalid}), 64'({1'b1, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
